mio_bus_xbar: RTL and testbench

// - Parametrised successor to the fixed-map MIO bus: one CPU master, N_SLAVES memory-mapped

---
 rtl/mio_bus_xbar_if.sv | 39 +++
 rtl/mio_bus_xbar.sv | 184 ++++++++++++++++++
 tb/tb_mio_bus_xbar.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_xbar_if.sv
// mio_bus_xbar_if
// Bundles the CPU-side request/response signals and the slave-side select/data
// signals of the MIO crossbar into one interface.
//   master modport : environment view (CPU drives requests, slave devices drive
//                    s_rdata/s_ack and observe the select/address/data outputs)
//   slave modport  : crossbar view (takes requests and slave responses, drives
//                    the completion pulse and the slave-side select/address/data)
// Parameters: N_SLAVES slave ports, DW data width, AW address width.
interface mio_bus_xbar_if #(
   parameter int N_SLAVES = 4,
   parameter int DW       = 32,
   parameter int AW       = 32
);
   // CPU side
   logic                   m_req;
   logic                   m_we;
   logic [AW-1:0]          m_addr;
   logic [DW-1:0]          m_wdata;
   logic [DW-1:0]          m_rdata;
   logic                   m_ready;
   logic                   m_err;
   // slave side
   logic [N_SLAVES-1:0]    s_sel;
   logic                   s_we;
   logic [AW-1:0]          s_addr;
   logic [DW-1:0]          s_wdata;
   logic [N_SLAVES*DW-1:0] s_rdata;
   logic [N_SLAVES-1:0]    s_ack;

   modport master (
      output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      input  m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata
   );

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      output m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata
   );
endinterface

// File: rtl/mio_bus_xbar.sv
// mio_bus_xbar
// One-master / N_SLAVES-slave memory-mapped crossbar with base/mask decode,
// req/ready handshake, slave wait states via ack, a timeout watchdog and error
// responses for unmapped or hung accesses. One transaction in flight at a time.
//   clk      : system clock, all state on rising edge
//   RSTN     : asynchronous reset, active-low
//   bus      : mio_bus_xbar_if.slave (m_* CPU handshake, s_* slave ports)
//   err_addr : last faulting address (only with MIO_BUS_ERR_LOG_EN)
//   err_cnt  : saturating fault count (only with MIO_BUS_ERR_LOG_EN)
// Optional feature macro: MIO_BUS_ERR_LOG_EN (fault logging registers).
// Without it err_addr/err_cnt are tied to 0; m_err is generated either way.
module mio_bus_xbar #(
   parameter int                       N_SLAVES = 4,
   parameter int                       DW       = 32,
   parameter int                       AW       = 32,
   parameter logic [N_SLAVES*AW-1:0]   BASE     = {32'hF000_0004, 32'hF000_0000,
                                                   32'hE000_0000, 32'h0000_0000},
   parameter logic [N_SLAVES*AW-1:0]   MASK     = {32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                                   32'hF000_0000, 32'hFFFF_F000},
   parameter int                       TIMEOUT  = 16
) (
   input  logic             clk,
   input  logic             RSTN,
   mio_bus_xbar_if.slave    bus,
   output logic [AW-1:0]    err_addr,
   output logic [7:0]       err_cnt
);

   localparam int               TMO_W    = $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t              state_reg;
   logic [TMO_W-1:0]    tmo_reg;

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic [N_SLAVES-1:0] match;
   logic [N_SLAVES-1:0] hit_onehot;
   logic [AW-1:0]       offset [N_SLAVES];
   logic [AW-1:0]       hit_offset;

   for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dec
      assign match[gi]  = (bus.m_addr & MASK[gi*AW +: AW]) == BASE[gi*AW +: AW];
      assign offset[gi] = bus.m_addr & ~MASK[gi*AW +: AW];
   end

   // Isolate the lowest set bit so the lowest slot wins on overlapping maps.
   assign hit_onehot = match & ~(match - N_SLAVES'(1));

   always_comb begin
      hit_offset = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (hit_onehot[i]) hit_offset = hit_offset | offset[i];
      end
   end

   // ---------------------------------------------------------------------
   // Response path: only the selected slot's ack/rdata are honoured
   // ---------------------------------------------------------------------
   logic [DW-1:0] sel_rdata;
   logic          ack_hit;

   assign ack_hit = |(bus.s_ack & bus.s_sel);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (bus.s_sel[i]) sel_rdata = sel_rdata | bus.s_rdata[i*DW +: DW];
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_reg   <= ST_IDLE;
         tmo_reg     <= '0;
         bus.s_sel   <= '0;
         bus.s_we    <= 1'b0;
         bus.s_addr  <= '0;
         bus.s_wdata <= '0;
         bus.m_ready <= 1'b0;
         bus.m_err   <= 1'b0;
         bus.m_rdata <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               bus.m_ready <= 1'b0;
               bus.m_err   <= 1'b0;
               if (bus.m_req) begin
                  bus.s_we    <= bus.m_we;
                  bus.s_wdata <= bus.m_wdata;
                  bus.s_addr  <= hit_offset;
                  tmo_reg     <= '0;
                  if (|match) begin
                     bus.s_sel <= hit_onehot;
                     state_reg <= ST_ACCESS;
                  end else begin
                     // Decode miss: answer immediately with an error.
                     bus.m_ready <= 1'b1;
                     bus.m_err   <= 1'b1;
                     bus.m_rdata <= '0;
                     state_reg   <= ST_RESP;
                  end
               end
            end

            ST_ACCESS: begin
               // An ack on the final watchdog cycle still counts as success.
               if (ack_hit) begin
                  bus.m_rdata <= bus.s_we ? '0 : sel_rdata;
                  bus.m_err   <= 1'b0;
                  bus.m_ready <= 1'b1;
                  bus.s_sel   <= '0;
                  state_reg   <= ST_RESP;
               end else if (tmo_reg == TMO_LAST) begin
                  bus.m_rdata <= '0;
                  bus.m_err   <= 1'b1;
                  bus.m_ready <= 1'b1;
                  bus.s_sel   <= '0;
                  state_reg   <= ST_RESP;
               end else begin
                  tmo_reg <= tmo_reg + TMO_W'(1);
               end
            end

            ST_RESP: begin
               // m_req may still be high here; it is only sampled again in IDLE.
               bus.m_ready <= 1'b0;
               bus.m_err   <= 1'b0;
               state_reg   <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Optional fault logging
   // ---------------------------------------------------------------------
`ifdef MIO_BUS_ERR_LOG_EN
   logic [AW-1:0] addr_reg;       // full address of the transaction in flight
   logic [AW-1:0] err_addr_reg;
   logic [7:0]    err_cnt_reg;
   logic          fault;
   logic [AW-1:0] fault_addr;

   assign fault = ((state_reg == ST_IDLE) && bus.m_req && !(|match)) ||
                  ((state_reg == ST_ACCESS) && !ack_hit && (tmo_reg == TMO_LAST));
   assign fault_addr = (state_reg == ST_IDLE) ? bus.m_addr : addr_reg;

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         addr_reg     <= '0;
         err_addr_reg <= '0;
         err_cnt_reg  <= '0;
      end else begin
         if ((state_reg == ST_IDLE) && bus.m_req) addr_reg <= bus.m_addr;
         if (fault) begin
            err_addr_reg <= fault_addr;
            if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
         end
      end
   end

   assign err_addr = err_addr_reg;
   assign err_cnt  = err_cnt_reg;
`else
   assign err_addr = '0;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_mio_bus_xbar.sv
// tb_mio_bus_xbar
// Directed bench for mio_bus_xbar (default map, TIMEOUT=16). Slave devices are
// modelled inline: the bench raises the target ack after a chosen number of
// wait states and presents distinct junk on the other rdata slots.
module tb_mio_bus_xbar;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic         clk;
   logic         RSTN;
   logic [AW-1:0] err_addr;
   logic [7:0]    err_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   mio_bus_xbar_if #(.N_SLAVES(N), .DW(DW), .AW(AW)) bus ();

   mio_bus_xbar #(.N_SLAVES(N), .DW(DW), .AW(AW), .TIMEOUT(16)) dut (
      .clk      (clk),
      .RSTN     (RSTN),
      .bus      (bus),
      .err_addr (err_addr),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one transaction. slot<0: no slave ever acks. noise: extra ack bits
   // driven every cycle (caller keeps them off the selected slot).
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int slot, input int waits, input logic [31:0] rd,
                          input logic [3:0] noise,
                          output int lat, output int sel_cyc, output logic [3:0] sel_seen,
                          output logic [31:0] wd_seen, output logic [31:0] sa_seen,
                          output logic we_seen, output logic [31:0] rdata_o, output logic err_o);
      bus.s_rdata = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
      if (slot >= 0) bus.s_rdata[slot*32 +: 32] = rd;
      bus.m_req   = 1'b1;
      bus.m_we    = we;
      bus.m_addr  = addr;
      bus.m_wdata = wd;
      bus.s_ack   = noise;
      sel_cyc  = 0;
      sel_seen = '0;
      wd_seen  = '0;
      sa_seen  = '0;
      we_seen  = 1'b0;
      tick();
      lat = 1;
      bus.m_req = 1'b0;   // dropping req mid-transaction must not abort it
      while (!bus.m_ready && lat < 40) begin
         if (bus.s_sel != '0) begin
            sel_cyc++;
            sel_seen = bus.s_sel;
            wd_seen  = bus.s_wdata;
            sa_seen  = bus.s_addr;
            we_seen  = bus.s_we;
         end
         bus.s_ack = noise;
         if (slot >= 0 && sel_cyc - 1 == waits) bus.s_ack[slot] = 1'b1;
         tick();
         lat++;
      end
      chk("ready_seen", {63'd0, bus.m_ready}, 64'd1);
      rdata_o = bus.m_rdata;
      err_o   = bus.m_err;
      chk("resp_sel_clear", {60'd0, bus.s_sel}, 64'd0);
      bus.s_ack = '0;
      tick();
      chk("ready_one_cycle", {63'd0, bus.m_ready}, 64'd0);
      $display("txn we=%0d addr=%08h lat=%0d sel_cycles=%0d rdata=%08h err=%0d",
               we, addr, lat, sel_cyc, rdata_o, err_o);
   endtask

   int          lat, sel_cyc;
   logic [3:0]  sel_seen;
   logic [31:0] wd_seen, sa_seen, rdata_o;
   logic        we_seen, err_o;
   logic [7:0]  exp_cnt;
   logic [31:0] exp_eaddr;

   initial begin
      RSTN        = 1'b0;
      bus.m_req   = 1'b0;
      bus.m_we    = 1'b0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.s_rdata = '0;
      bus.s_ack   = '0;
      tick();
      tick();
      chk("rst_ready", {63'd0, bus.m_ready}, 64'd0);
      chk("rst_err",   {63'd0, bus.m_err},   64'd0);
      chk("rst_rdata", {32'd0, bus.m_rdata}, 64'd0);
      chk("rst_sel",   {60'd0, bus.s_sel},   64'd0);
      chk("rst_we",    {63'd0, bus.s_we},    64'd0);
      chk("rst_saddr", {32'd0, bus.s_addr},  64'd0);
      chk("rst_swdata",{32'd0, bus.s_wdata}, 64'd0);
      chk("rst_errcnt",{56'd0, err_cnt},     64'd0);
      chk("rst_erradr",{32'd0, err_addr},    64'd0);
      @(negedge clk);
      RSTN = 1'b1;
      tick();

      // Zero-wait read from slave 0
      run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 0, 32'h1234_5678, 4'b0000,
              lat, sel_cyc, sel_seen, wd_seen, sa_seen, we_seen, rdata_o, err_o);
      chk("rd0_lat",   lat, 2);
      chk("rd0_sel",   {60'd0, sel_seen}, 64'h1);
      chk("rd0_saddr", {32'd0, sa_seen}, 64'h10);
      chk("rd0_rdata", {32'd0, rdata_o}, 64'h1234_5678);
      chk("rd0_err",   {63'd0, err_o}, 64'd0);

      // Write to slave 2 with 3 wait states
      run_txn(1'b1, 32'hF000_0000, 32'h0000_A5A5, 2, 3, 32'hFFFF_FFFF, 4'b0000,
              lat, sel_cyc, sel_seen, wd_seen, sa_seen, we_seen, rdata_o, err_o);
      chk("wr2_lat",    lat, 5);
      chk("wr2_selcyc", sel_cyc, 4);
      chk("wr2_sel",    {60'd0, sel_seen}, 64'h4);
      chk("wr2_wdata",  {32'd0, wd_seen}, 64'hA5A5);
      chk("wr2_we",     {63'd0, we_seen}, 64'd1);
      chk("wr2_rdata",  {32'd0, rdata_o}, 64'd0);
      chk("wr2_err",    {63'd0, err_o}, 64'd0);

      // Unmapped read
      run_txn(1'b0, 32'h8000_0000, 32'h0, -1, 0, 32'h0, 4'b0000,
              lat, sel_cyc, sel_seen, wd_seen, sa_seen, we_seen, rdata_o, err_o);
      chk("miss_lat",    lat, 1);
      chk("miss_selcyc", sel_cyc, 0);
      chk("miss_rdata",  {32'd0, rdata_o}, 64'd0);
      chk("miss_err",    {63'd0, err_o}, 64'd1);
`ifdef MIO_BUS_ERR_LOG_EN
      exp_cnt = 8'd1; exp_eaddr = 32'h8000_0000;
`else
      exp_cnt = 8'd0; exp_eaddr = 32'h0;
`endif
      chk("miss_errcnt", {56'd0, err_cnt}, {56'd0, exp_cnt});
      chk("miss_erradr", {32'd0, err_addr}, {32'd0, exp_eaddr});

      // Slave 1 never acks; acks on other slots must be ignored
      run_txn(1'b0, 32'hE000_0000, 32'h0, -1, 0, 32'h0, 4'b1101,
              lat, sel_cyc, sel_seen, wd_seen, sa_seen, we_seen, rdata_o, err_o);
      chk("tmo_lat",    lat, 17);
      chk("tmo_selcyc", sel_cyc, 16);
      chk("tmo_sel",    {60'd0, sel_seen}, 64'h2);
      chk("tmo_rdata",  {32'd0, rdata_o}, 64'd0);
      chk("tmo_err",    {63'd0, err_o}, 64'd1);
`ifdef MIO_BUS_ERR_LOG_EN
      exp_cnt = 8'd2; exp_eaddr = 32'hE000_0000;
`endif
      chk("tmo_errcnt", {56'd0, err_cnt}, {56'd0, exp_cnt});
      chk("tmo_erradr", {32'd0, err_addr}, {32'd0, exp_eaddr});

      // Ack arrives on the last watchdog cycle (tmo=15): success wins
      run_txn(1'b0, 32'hE000_0100, 32'h0, 1, 15, 32'hCAFE_F00D, 4'b0000,
              lat, sel_cyc, sel_seen, wd_seen, sa_seen, we_seen, rdata_o, err_o);
      chk("late_lat",   lat, 17);
      chk("late_rdata", {32'd0, rdata_o}, 64'hCAFE_F00D);
      chk("late_err",   {63'd0, err_o}, 64'd0);
      chk("late_saddr", {32'd0, sa_seen}, 64'h0000_0100);

      // Slave 3 read with one wait state
      run_txn(1'b0, 32'hF000_0006, 32'h0, 3, 1, 32'h0BAD_BEEF, 4'b0000,
              lat, sel_cyc, sel_seen, wd_seen, sa_seen, we_seen, rdata_o, err_o);
      chk("rd3_lat",   lat, 3);
      chk("rd3_sel",   {60'd0, sel_seen}, 64'h8);
      chk("rd3_saddr", {32'd0, sa_seen}, 64'h2);
      chk("rd3_rdata", {32'd0, rdata_o}, 64'h0BAD_BEEF);

      // Asynchronous reset in the middle of ACCESS
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b0;
      bus.m_addr = 32'h0000_0020;
      bus.s_ack  = '0;
      tick();
      chk("mid_sel_before", {60'd0, bus.s_sel}, 64'h1);
      bus.m_req = 1'b0;
      #2;
      RSTN = 1'b0;
      #1;
      chk("mid_sel_after",   {60'd0, bus.s_sel}, 64'd0);
      chk("mid_ready_after", {63'd0, bus.m_ready}, 64'd0);
      chk("mid_errcnt",      {56'd0, err_cnt}, 64'd0);
      @(negedge clk);
      RSTN = 1'b1;
      tick();
      run_txn(1'b0, 32'h0000_0020, 32'h0, 0, 0, 32'h5555_AAAA, 4'b0000,
              lat, sel_cyc, sel_seen, wd_seen, sa_seen, we_seen, rdata_o, err_o);
      chk("post_rst_lat",   lat, 2);
      chk("post_rst_rdata", {32'd0, rdata_o}, 64'h5555_AAAA);

      // 300 unmapped accesses: counter saturation
      for (int k = 0; k < 300; k++) begin
         run_txn(1'b0, 32'h8000_0000 + 32'(k*4), 32'h0, -1, 0, 32'h0, 4'b0000,
                 lat, sel_cyc, sel_seen, wd_seen, sa_seen, we_seen, rdata_o, err_o);
      end
      chk("sat_last_err", {63'd0, err_o}, 64'd1);
`ifdef MIO_BUS_ERR_LOG_EN
      exp_cnt = 8'hFF; exp_eaddr = 32'h8000_0000 + 32'(299*4);
`else
      exp_cnt = 8'h00; exp_eaddr = 32'h0;
`endif
      chk("sat_errcnt", {56'd0, err_cnt}, {56'd0, exp_cnt});
      chk("sat_erradr", {32'd0, err_addr}, {32'd0, exp_eaddr});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
